// File: rtl/ofifo_col_align.sv
// ofifo_col_align
// Realigns per-column psum streams leaving the MAC array. Each column pushes on
// its own valid strobe into a private FIFO. A full psum vector is popped only
// once every column holds at least one entry, so staggered column completion
// (WS skew or OS flush) is hidden from the SRAM write path.
module ofifo_col_align #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [psum_bw*col-1:0]   in,
  input  logic [col-1:0]           wr,
  input  logic                     rd,
  output logic                     o_full,
  output logic                     o_ready,
  output logic                     o_valid,
  output logic [psum_bw*col-1:0]   out,
  output logic                     out_vld,
  output logic                     ovf_err,
  output logic                     udf_err
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // without a separate occupancy counter.
  localparam int addr_bw = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [addr_bw:0] PTR_INC = (addr_bw + 1)'(1);

  // Per-column status, built inside the generate loop below.
  logic [col-1:0] w_empty;
  logic [col-1:0] w_full;
  logic [col-1:0] w_push;

  // Vector-level control shared by every column.
  logic w_valid;
  logic w_pop;
  logic w_any_ovf;
  logic w_udf;

  // A vector is available only when no column is empty.
  assign w_valid   = ~|w_empty;
  // Pops are all-or-nothing across columns to keep the vector aligned.
  assign w_pop     = rd & w_valid;
  // Fullness uses pre-edge pointers, so a push to a column popped in the same
  // cycle while full is still dropped.
  assign w_any_ovf = |(wr & w_full);
  assign w_udf     = rd & ~w_valid;

  generate
    for (genvar gi = 0; gi < col; gi++) begin : g_col
      logic [psum_bw-1:0] r_mem [depth];
      logic [addr_bw:0]   r_wptr;
      logic [addr_bw:0]   r_rptr;
      logic [psum_bw-1:0] r_head;
      logic [psum_bw-1:0] w_din;

      assign w_din       = in[psum_bw*gi +: psum_bw];
      assign w_empty[gi] = (r_wptr == r_rptr);
      assign w_full[gi]  = (r_wptr[addr_bw] != r_rptr[addr_bw]) &&
                           (r_wptr[addr_bw-1:0] == r_rptr[addr_bw-1:0]);
      assign w_push[gi]  = wr[gi] & ~w_full[gi];

      // Storage write; contents are intentionally not reset so this maps to block RAM.
      always_ff @(posedge clk) begin
        if (w_push[gi]) begin
          r_mem[r_wptr[addr_bw-1:0]] <= w_din;
        end
      end

      // Pointer update; reset discards all queued entries and overrides wr/rd.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_wptr <= '0;
          r_rptr <= '0;
        end else begin
          if (w_push[gi]) begin
            r_wptr <= r_wptr + PTR_INC;
          end
          if (w_pop) begin
            r_rptr <= r_rptr + PTR_INC;
          end
        end
      end

      // Registered head read; holds its value whenever no pop occurs.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_head <= '0;
        end else if (w_pop) begin
          r_head <= r_mem[r_rptr[addr_bw-1:0]];
        end
      end

      assign out[psum_bw*gi +: psum_bw] = r_head;
    end
  endgenerate

  logic r_out_vld;
  logic r_ovf_err;
  logic r_udf_err;

  // Pop strobe and sticky error flags; the flags clear only on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_vld <= 1'b0;
      r_ovf_err <= 1'b0;
      r_udf_err <= 1'b0;
    end else begin
      r_out_vld <= w_pop;
      if (w_any_ovf) begin
        r_ovf_err <= 1'b1;
      end
      if (w_udf) begin
        r_udf_err <= 1'b1;
      end
    end
  end

  assign o_valid = w_valid;
  assign o_full  = |w_full;
  assign o_ready = ~(|w_full);
  assign out_vld = r_out_vld;
  assign ovf_err = r_ovf_err;
  assign udf_err = r_udf_err;

endmodule
